uart_rx_frame_ctrl: RTL and testbench
=====================================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum payload bytes per frame (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 60000, SHALL set the inter-byte timeout in clk cycles.
REQ-003 Parameter SOF_BYTE, default 8'hA5, SHALL set the start-of-frame marker.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 cfg_enable  input  1  frame reception enable.
REQ-007 uart_rx_en  output  1  receiver enable to UART RX; equals registered cfg_enable.
REQ-008 rx_valid  input  1  one-cycle byte strobe from UART RX.
REQ-009 rx_break  input  1  BREAK indication from UART RX; qualified by rx_valid.
REQ-010 rx_data  input  8  received byte.
REQ-011 out_valid / out_ready / out_last  output / input / output  1 each  payload stream handshake; out_last marks final byte.
REQ-012 out_data  output  8  payload byte.
REQ-013 err_pulse  output  1  one-cycle pulse on any frame error.
REQ-014 err_code  output  3  cause of last error: 1 len, 2 csum, 3 timeout, 4 break, 5 overrun; held until next error.
REQ-015 frame_ok_cnt / frame_err_cnt  output  8 each  saturating counters of good/bad frames.

Function
REQ-016 Frame format SHALL be SOF_BYTE, LEN, LEN payload bytes, CSUM; CSUM SHALL equal the 8-bit mod-256 sum of LEN and all payload bytes.
REQ-017 FSM states SHALL be IDLE, LEN, PAYLOAD, CSUM, DRAIN.
REQ-018 IDLE: on rx_valid with rx_data==SOF_BYTE -> LEN; other bytes ignored silently.
REQ-019 LEN: on rx_valid, LEN==0 or LEN>MAX_LEN -> IDLE with error len; else store LEN, seed sum with LEN, -> PAYLOAD.
REQ-020 PAYLOAD: each rx_valid writes rx_data to buffer at index byte_cnt, adds to sum, increments byte_cnt; after byte LEN -> CSUM.
REQ-021 CSUM: on rx_valid, match -> DRAIN and frame_ok_cnt+1; mismatch -> IDLE with error csum.
REQ-022 DRAIN: out_valid SHALL be high with out_data=buffer[rd_idx]; index advances only when out_valid&&out_ready; out_last high on index LEN-1; the transfer of the last byte -> IDLE.
REQ-023 out_data, out_last SHALL remain stable while out_valid&&!out_ready.
REQ-024 First payload byte SHALL appear on out_valid the cycle after the CSUM byte's rx_valid (latency 1).
REQ-025 rx_valid in DRAIN SHALL be dropped and raise error overrun without leaving DRAIN; frame_err_cnt+1.
REQ-026 Timeout counter SHALL clear on every rx_valid and count in LEN, PAYLOAD, CSUM; reaching TIMEOUT_CYCLES -> IDLE with error timeout.
REQ-027 rx_valid&&rx_break in any state SHALL abort to IDLE with error break (in IDLE too), overriding all other transitions.
REQ-028 Each error SHALL pulse err_pulse once, update err_code, increment frame_err_cnt.
REQ-029 Counters SHALL saturate at 255, never wrap.
REQ-030 cfg_enable low SHALL force IDLE next cycle, clear out_valid, and raise no error; an in-flight frame is discarded.
REQ-031 Simultaneous timeout expiry and rx_valid SHALL be resolved in favour of rx_valid.

Reset
REQ-032 On resetn low: state IDLE, uart_rx_en 0, out_valid 0, out_last 0, out_data 0, err_pulse 0, err_code 0, both counters 0, byte_cnt/rd_idx/sum/timeout counter 0.
REQ-033 Reset mid-frame or mid-drain SHALL discard the frame without error reporting; buffer contents need not be cleared.

Structure
REQ-034 Shared package uart_pkg SHALL hold the FSM state encoding, err_code constants, and default SOF_BYTE.
REQ-035 The payload store SHALL be a sub-module uart_frame_buf (MAX_LEN x 8, one write port, one async-read port).

Verification
REQ-036 Good frame A5 03 11 22 33 69, out_ready=1 -> out 11,22,33, last on 33, frame_ok_cnt=1.
REQ-037 Bad checksum A5 02 10 20 00 -> err_code=2, one err_pulse, no out_valid, frame_err_cnt=1.
REQ-038 LEN=0x11 with MAX_LEN=16 -> err_code=1, return to IDLE, next good frame accepted.
REQ-039 A5 02 10 then silence TIMEOUT_CYCLES -> err_code=3; a one-cycle-early byte resets the timer instead.
REQ-040 Good frame with out_ready held low 10 cycles then byte 0x55 arriving -> err_code=5, data stable, stream completes intact once out_ready=1.
REQ-041 Break (rx_valid, rx_break, 00) mid-PAYLOAD -> err_code=4, IDLE; resetn pulse mid-DRAIN -> all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller: FSM encoding,
// error cause codes and the default start-of-frame marker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_BREAK   = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: single write port, asynchronous read port so
// the drained byte follows the read index in the same cycle.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Receives SOF/LEN/payload/CSUM frames from a UART RX byte stream, validates
// them and replays the payload on a ready/valid stream.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 60000,
  parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF_BYTE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cfg_enable,
  output logic       uart_rx_en,
  input  logic       rx_valid,
  input  logic       rx_break,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] out_data,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic [7:0] frame_ok_cnt,
  output logic [7:0] frame_err_cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_pulse_q, err_pulse_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [7:0]    ok_cnt_q, ok_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          uart_rx_en_q, uart_rx_en_d;

  logic          err_raise;
  logic [2:0]    err_cause;
  logic          ok_inc;
  logic          wr_en;
  logic          counting;
  logic [7:0]    buf_rd_data;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (byte_cnt_q[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_idx_q[AW-1:0]),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    rd_idx_d   = rd_idx_q;
    sum_d      = sum_q;
    tmo_d      = '0;
    err_raise  = 1'b0;
    err_cause  = ERR_NONE;
    ok_inc     = 1'b0;
    wr_en      = 1'b0;
    counting   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

    // Disable silently discards; break beats everything else; an arriving
    // byte always beats a timeout expiring in the same cycle.
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else if (rx_valid && rx_break) begin
      state_d   = ST_IDLE;
      err_raise = 1'b1;
      err_cause = ERR_BREAK;
    end else if (counting && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        err_raise = 1'b1;
        err_cause = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == SOF_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            state_d   = ST_IDLE;
            err_raise = 1'b1;
            err_cause = ERR_LEN;
          end else begin
            len_d      = rx_data;
            sum_d      = rx_data;
            byte_cnt_d = 8'd0;
            state_d    = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en      = 1'b1;
          sum_d      = sum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_d == len_q) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            state_d  = ST_DRAIN;
            rd_idx_d = 8'd0;
            ok_inc   = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            err_raise = 1'b1;
            err_cause = ERR_CSUM;
          end
        end
        ST_DRAIN: begin
          if (rx_valid) begin
            err_raise = 1'b1;
            err_cause = ERR_OVERRUN;
          end
          if (out_ready) begin
            if (rd_idx_q == len_q - 8'd1) state_d = ST_IDLE;
            else rd_idx_d = rd_idx_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) begin
      byte_cnt_d = 8'd0;
      rd_idx_d   = 8'd0;
      sum_d      = 8'd0;
      tmo_d      = '0;
    end

    err_pulse_d  = err_raise;
    err_code_d   = err_raise ? err_cause : err_code_q;
    err_cnt_d    = err_raise ? sat_inc(err_cnt_q) : err_cnt_q;
    ok_cnt_d     = ok_inc ? sat_inc(ok_cnt_q) : ok_cnt_q;
    uart_rx_en_d = cfg_enable;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      len_q        <= 8'd0;
      byte_cnt_q   <= 8'd0;
      rd_idx_q     <= 8'd0;
      sum_q        <= 8'd0;
      tmo_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      ok_cnt_q     <= 8'd0;
      err_cnt_q    <= 8'd0;
      uart_rx_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_idx_q     <= rd_idx_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
      uart_rx_en_q <= uart_rx_en_d;
    end
  end

  assign out_valid     = (state_q == ST_DRAIN);
  assign out_data      = out_valid ? buf_rd_data : 8'h00;
  assign out_last      = out_valid && (rd_idx_q == len_q - 8'd1);
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;
  assign uart_rx_en    = uart_rx_en_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, timeout, overrun,
// break and reset, with hand-computed expectations.
module tb_uart_rx_frame_ctrl;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_enable;
  logic       uart_rx_en;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] rx_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] out_data;
  logic       err_pulse;
  logic [2:0] err_code;
  logic [7:0] frame_ok_cnt;
  logic [7:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int base;
  logic [8:0] out_log[$];
  logic [7:0] seq[$];

  uart_rx_frame_ctrl #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (T),
    .SOF_BYTE       (8'hA5)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_enable    (cfg_enable),
    .uart_rx_en    (uart_rx_en),
    .rx_valid      (rx_valid),
    .rx_break      (rx_break),
    .rx_data       (rx_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_data      (out_data),
    .err_pulse     (err_pulse),
    .err_code      (err_code),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) out_log.push_back({out_last, out_data});
    if (err_pulse === 1'b1) err_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic brk);
    rx_valid = 1'b1;
    rx_break = brk;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic play();
    foreach (seq[i]) send_byte(seq[i], 1'b0);
  endtask

  initial begin
    resetn = 1'b0; cfg_enable = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
    rx_data = 8'h00; out_ready = 1'b1;
    idle(3);
    check("rst_rx_en", uart_rx_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_ok_cnt", frame_ok_cnt, 0);
    check("rst_err_cnt", frame_err_cnt, 0);
    resetn = 1'b1; cfg_enable = 1'b1;
    idle(1);
    check("rx_en_on", uart_rx_en, 1);

    // Good frame, ready held high
    out_log.delete();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    play();
    check("good_lat_valid", out_valid, 1);
    check("good_lat_data", out_data, 8'h11);
    check("good_lat_last", out_last, 0);
    idle(4);
    check("good_n", out_log.size(), 3);
    check("good_b0", out_log[0], 9'h011);
    check("good_b1", out_log[1], 9'h022);
    check("good_b2", out_log[2], 9'h133);
    check("good_ok_cnt", frame_ok_cnt, 1);
    check("good_valid_off", out_valid, 0);
    check("good_no_err", err_seen, 0);

    // Bad checksum
    out_log.delete();
    base = err_seen;
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    play();
    check("csum_pulse", err_pulse, 1);
    check("csum_code", err_code, 3'd2);
    check("csum_err_cnt", frame_err_cnt, 1);
    idle(3);
    check("csum_pulse_once", err_seen - base, 1);
    check("csum_no_out", out_log.size(), 0);
    check("csum_valid_off", out_valid, 0);

    // Oversized LEN, then a good frame is still accepted
    seq = '{8'hA5, 8'h11};
    play();
    check("len_code", err_code, 3'd1);
    check("len_err_cnt", frame_err_cnt, 2);
    out_log.delete();
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    play();
    idle(2);
    check("len_next_ok", frame_ok_cnt, 2);
    check("len_next_n", out_log.size(), 1);
    check("len_next_b0", out_log[0], 9'h17E);

    // Byte on the expiry cycle wins; a byte one cycle early resets the timer
    out_log.delete();
    base = err_seen;
    seq = '{8'hA5, 8'h02, 8'h10};
    play();
    idle(T - 1);
    send_byte(8'h20, 1'b0);
    idle(T - 2);
    send_byte(8'h32, 1'b0);
    idle(3);
    check("tmo_edge_ok", frame_ok_cnt, 3);
    check("tmo_edge_no_err", err_seen - base, 0);
    check("tmo_edge_n", out_log.size(), 2);
    check("tmo_edge_b1", out_log[1], 9'h120);
    seq = '{8'hA5, 8'h02, 8'h10};
    play();
    idle(T - 1);
    check("tmo_not_yet", err_pulse, 0);
    idle(1);
    check("tmo_pulse", err_pulse, 1);
    check("tmo_code", err_code, 3'd3);
    check("tmo_err_cnt", frame_err_cnt, 3);

    // Overrun while stalled in drain
    out_log.delete();
    out_ready = 1'b0;
    seq = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h7A};
    play();
    check("ovr_valid", out_valid, 1);
    check("ovr_data0", out_data, 8'hAB);
    idle(10);
    check("ovr_stable_data", out_data, 8'hAB);
    check("ovr_stable_last", out_last, 0);
    send_byte(8'h55, 1'b0);
    check("ovr_pulse", err_pulse, 1);
    check("ovr_code", err_code, 3'd5);
    check("ovr_err_cnt", frame_err_cnt, 4);
    check("ovr_still_valid", out_valid, 1);
    check("ovr_data_kept", out_data, 8'hAB);
    out_ready = 1'b1;
    idle(3);
    check("ovr_n", out_log.size(), 2);
    check("ovr_b0", out_log[0], 9'h0AB);
    check("ovr_b1", out_log[1], 9'h1CD);
    check("ovr_ok_cnt", frame_ok_cnt, 4);

    // Break mid-payload, then recovery
    seq = '{8'hA5, 8'h03, 8'h01};
    play();
    send_byte(8'h00, 1'b1);
    check("brk_code", err_code, 3'd4);
    check("brk_err_cnt", frame_err_cnt, 5);
    check("brk_valid_off", out_valid, 0);
    out_log.delete();
    seq = '{8'hA5, 8'h01, 8'h02, 8'h03};
    play();
    idle(2);
    check("brk_next_ok", frame_ok_cnt, 5);
    check("brk_next_b0", out_log[0], 9'h102);

    // Reset in the middle of a drain
    out_ready = 1'b0;
    base = err_seen;
    seq = '{8'hA5, 8'h01, 8'h44, 8'h45};
    play();
    check("mrst_pre_valid", out_valid, 1);
    check("mrst_pre_last", out_last, 1);
    resetn = 1'b0;
    idle(1);
    check("mrst_valid", out_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_data", out_data, 0);
    check("mrst_rx_en", uart_rx_en, 0);
    check("mrst_err_code", err_code, 0);
    check("mrst_ok_cnt", frame_ok_cnt, 0);
    check("mrst_err_cnt", frame_err_cnt, 0);
    check("mrst_no_err", err_seen - base, 0);
    resetn = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
